// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Latency/backpressure: none (definitions only).
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 8 * HDR_BYTES;

  function automatic logic is_busy(input state_t s);
    return (s == S_HDR_HI) || (s == S_HDR_LO) || (s == S_DATA) ||
           (s == S_WRITE)  || (s == S_CHK);
  endfunction

endpackage

// File: rtl/word_packer.sv
// Big-endian byte-to-word packer with 2-bit byte counter (running XOR under PROG_LOADER_CHECKSUM_EN).
// Latency 0 (word_nxt is combinational); no backpressure, shifts only when told to.
module word_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_nxt,
  output logic        full
`ifdef PROG_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]  xsum
`endif
);

  localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);

  logic [23:0] sr;
  logic [1:0]  cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift) begin
      sr  <= {sr[15:0], byte_in};
      cnt <= cnt + 2'd1;
    end
  end

  // full: the byte being offered now completes the word
  assign word_nxt = {sr, byte_in};
  assign full     = (cnt == LAST);

`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     xsum <= '0;
    else if (clear) xsum <= '0;
    else if (shift) xsum <= xsum ^ byte_in;
  end
`endif

endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed byte stream as big-endian words into imem; PROG_LOADER_CHECKSUM_EN adds a trailing XOR byte.
// im_we pulses the cycle after each 4th byte; byte_ready is low in IDLE/WRITE/DONE/ERR.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_run
);

  state_t             state, state_d;
  logic [7:0]         len_hi;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_hdr;
  logic [ADDR_W-1:0]  word_idx;
  logic               accept;
  logic               last_word;
  logic               pk_clear;
  logic               pk_shift;
  logic               pk_full;
  logic [31:0]        pk_word;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]         pk_xsum;
`endif

  assign accept    = byte_valid & byte_ready;
  assign len_hdr   = {len_hi, byte_in};
  assign last_word = (32'(word_idx) + 32'd1) == 32'(len_q);
  assign pk_shift  = accept && (state == S_DATA);

  word_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (pk_clear),
    .shift    (pk_shift),
    .byte_in  (byte_in),
    .word_nxt (pk_word),
    .full     (pk_full)
`ifdef PROG_LOADER_CHECKSUM_EN
    ,
    .xsum     (pk_xsum)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d    = state;
    byte_ready = 1'b0;
    pk_clear   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d  = S_HDR_HI;
          pk_clear = 1'b1;
        end
      end
      S_HDR_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) state_d = S_HDR_LO;
      end
      S_HDR_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (len_hdr == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else if (32'(len_hdr) > 32'(MAX_WORDS)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        if (byte_valid && pk_full) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: begin
        byte_ready = 1'b1;
        if (byte_valid) state_d = (byte_in == pk_xsum) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: begin
        if (start) begin
          state_d  = S_HDR_HI;
          pk_clear = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address/data are latched with the 4th byte so they hold between writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_hi   <= '0;
      len_q    <= '0;
      word_idx <= '0;
      im_addr  <= '0;
      im_wdata <= '0;
    end else begin
      if (accept && state == S_HDR_HI) len_hi <= byte_in;
      if (accept && state == S_HDR_LO) begin
        len_q    <= len_hdr;
        word_idx <= '0;
      end
      if (pk_shift && pk_full) begin
        im_addr  <= 32'({word_idx, 2'b00});
        im_wdata <= pk_word;
      end
      if (state == S_WRITE) word_idx <= word_idx + 1'b1;
    end
  end

  assign im_we   = (state == S_WRITE);
  assign busy    = is_busy(state);
  assign done    = (state == S_DONE);
  assign err     = (state == S_ERR);
  assign cpu_run = done;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized/directed bench for prog_loader against a queue-based image model.
`timescale 1ns/1ns
module tb_prog_loader;

  localparam int ADDR_W = 8;
  localparam int MAXW   = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready, im_we, busy, done, err, cpu_run;
  logic [31:0] im_addr, im_wdata;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          timed_out = 1'b0;
  logic [31:0] wq_a[$];
  logic [31:0] wq_d[$];

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAXW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cpu_run    (cpu_run)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory-side observer: every write pulse is logged, and the stream must be stalled during it
  always @(negedge clk) begin
    if (rst_n && im_we) begin
      wq_a.push_back(im_addr);
      wq_d.push_back(im_wdata);
      check("ready_low_in_write", 32'(byte_ready), 32'd0);
    end
  end

  function automatic int gapf(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return int'($urandom_range(0, 2));
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waitc;
    waitc = 0;
    repeat (gap) begin
      byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!byte_ready) timed_out = 1'b1;
    else begin
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Full load: header, data, optional checksum; result judged from the image rules alone
  task automatic run_load(input string tag, input int n, input logic [7:0] din[$],
                          input int mode, input bit bad_ck, input bit poke);
    logic [15:0] nn;
    logic [7:0]  ck;
    time         t0, t1;
    int          waitc, expw, m, exp_lat;
    bit          ok;
    nn = 16'(n);
    ck = 8'h00;
    foreach (din[i]) ck ^= din[i];
    timed_out = 1'b0;
    wq_a.delete();
    wq_d.delete();
    pulse_start();
    t0 = $time;
    send_byte(nn[15:8], gapf(mode));
    send_byte(nn[7:0], gapf(mode));
    if (n <= MAXW) begin
      foreach (din[i]) begin
        if (poke && i == 2) pulse_start();
        send_byte(din[i], gapf(mode));
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      send_byte(ck ^ 8'(bad_ck), gapf(mode));
`endif
    end
    waitc = 0;
    while (!(done || err) && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!(done || err)) timed_out = 1'b1;
    t1 = $time;

    ok = (n <= MAXW);
`ifdef PROG_LOADER_CHECKSUM_EN
    ok = ok && !bad_ck;
    exp_lat = (n <= MAXW) ? 3 + 5 * n : 2;
`else
    exp_lat = (n <= MAXW) ? 2 + 5 * n : 2;
`endif
    expw = (n <= MAXW) ? n : 0;

    check({tag, "_timeout"}, 32'(timed_out), 32'd0);
    check({tag, "_done"}, 32'(done), 32'(ok));
    check({tag, "_err"}, 32'(err), 32'(!ok));
    check({tag, "_cpu_run"}, 32'(cpu_run), 32'(ok));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_nwrites"}, 32'(wq_a.size()), 32'(expw));
    m = (wq_a.size() < expw) ? wq_a.size() : expw;
    for (int i = 0; i < m; i++) begin
      check({tag, "_addr"}, wq_a[i], 32'(4 * i));
      check({tag, "_data"}, wq_d[i], {din[4*i], din[4*i+1], din[4*i+2], din[4*i+3]});
    end
    if (mode == 0) check({tag, "_latency"}, 32'((t1 - t0) / 10), 32'(exp_lat));
  endtask

  initial begin
    logic [7:0] vec[$];
    logic [7:0] rnd[$];
    logic [7:0] none[$];
    int         n;

    #12;
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_im_we", 32'(im_we), 32'd0);
    check("rst_im_addr", im_addr, 32'd0);
    check("rst_im_wdata", im_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", 32'(byte_ready), 32'd0);

    // Directed image from a real program
    vec = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    run_load("vec", 2, vec, 0, 1'b0, 1'b0);
    check("vec_word0", (wq_d.size() > 0) ? wq_d[0] : 32'hDEAD_BEEF, 32'h2008_0005);
    check("vec_word1", (wq_d.size() > 1) ? wq_d[1] : 32'hDEAD_BEEF, 32'h8C09_0004);
    check("vec_addr1", (wq_a.size() > 1) ? wq_a[1] : 32'hDEAD_BEEF, 32'h0000_0004);
    run_load("vec_toggle", 2, vec, 1, 1'b0, 1'b0);

    run_load("empty", 0, none, 0, 1'b0, 1'b0);
    run_load("too_long", MAXW + 1, none, 0, 1'b0, 1'b0);

    // Reset mid-load: word 0 lands, then abort inside word 1
    wq_a.delete();
    wq_d.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h50 + i), 0);
    rst_n = 1'b0;
    #1;
    check("abort_cpu_run", 32'(cpu_run), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_writes", 32'(wq_a.size()), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vec = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load("after_abort", 1, vec, 0, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 6));
      rnd.delete();
      for (int i = 0; i < 4 * n; i++) rnd.push_back(8'($urandom));
      run_load("rand", n, rnd, r % 3, 1'b0, r == 1);
    end

    rnd.delete();
    for (int i = 0; i < 4 * MAXW; i++) rnd.push_back(8'($urandom));
    run_load("max_len", MAXW, rnd, 0, 1'b0, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
    vec = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load("ck_good", 1, vec, 0, 1'b0, 1'b0);
    run_load("ck_bad", 1, vec, 0, 1'b1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
